// File: rtl/spike_window_counter.sv
// Spike-rate window counter: counts spikes over a programmable number of enabled cycles
// and holds the result on a valid/ready port. Define SPIKE_WINDOW_PEAK_EN to also track peak membrane.
module spike_window_counter #(
   parameter int COUNT_BITS    = 8,
   parameter int WINDOW_BITS   = 8,
   parameter int MEMBRANE_BITS = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [WINDOW_BITS-1:0]   window_len,
   input  logic                     enable,
   input  logic                     spike_in,
   input  logic [MEMBRANE_BITS-1:0] membrane_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [COUNT_BITS-1:0]    out_count,
   output logic                     out_overflow,
   output logic [MEMBRANE_BITS-1:0] out_peak,
   output logic                     busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      HOLD  = 2'b10
   } state_t;

   localparam logic [WINDOW_BITS-1:0] WIN_ONE   = WINDOW_BITS'(1);
   localparam logic [COUNT_BITS-1:0]  COUNT_ONE = COUNT_BITS'(1);

   state_t                  state_q, state_d;
   logic [WINDOW_BITS-1:0]  remaining_q, remaining_d;
   logic [COUNT_BITS-1:0]   count_q, count_d;
   logic                    overflow_q, overflow_d;
   logic [COUNT_BITS-1:0]   outCount_q, outCount_d;
   logic                    outOverflow_q, outOverflow_d;
   logic                    startAccept;

`ifdef SPIKE_WINDOW_PEAK_EN
   logic [MEMBRANE_BITS-1:0] peak_q, peak_d;
   logic [MEMBRANE_BITS-1:0] outPeak_q, outPeak_d;
`endif

   // A new window may only open from IDLE, or from HOLD when the result is taken this cycle.
   assign startAccept = start && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));

   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      count_d       = count_q;
      overflow_d    = overflow_q;
      outCount_d    = outCount_q;
      outOverflow_d = outOverflow_q;
`ifdef SPIKE_WINDOW_PEAK_EN
      peak_d        = peak_q;
      outPeak_d     = outPeak_q;
`endif
      case (state_q)
         IDLE: ;
         COUNT: begin
            if (enable) begin
               remaining_d = remaining_q - WIN_ONE;
               if (spike_in) begin
                  if (count_q == {COUNT_BITS{1'b1}}) overflow_d = 1'b1;
                  else                               count_d    = count_q + COUNT_ONE;
               end
`ifdef SPIKE_WINDOW_PEAK_EN
               if (membrane_in > peak_q) peak_d = membrane_in;
`endif
               // The last enabled sample is folded into the published result.
               if (remaining_q == WIN_ONE) begin
                  state_d       = HOLD;
                  outCount_d    = count_d;
                  outOverflow_d = overflow_d;
`ifdef SPIKE_WINDOW_PEAK_EN
                  outPeak_d     = peak_d;
`endif
               end
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (startAccept) begin
         count_d    = '0;
         overflow_d = 1'b0;
`ifdef SPIKE_WINDOW_PEAK_EN
         peak_d     = '0;
`endif
         if (window_len != '0) begin
            state_d     = COUNT;
            remaining_d = window_len;
         end else begin
            state_d       = HOLD;
            remaining_d   = '0;
            outCount_d    = '0;
            outOverflow_d = 1'b0;
`ifdef SPIKE_WINDOW_PEAK_EN
            outPeak_d     = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         remaining_q   <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         outCount_q    <= '0;
         outOverflow_q <= 1'b0;
`ifdef SPIKE_WINDOW_PEAK_EN
         peak_q        <= '0;
         outPeak_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         outCount_q    <= outCount_d;
         outOverflow_q <= outOverflow_d;
`ifdef SPIKE_WINDOW_PEAK_EN
         peak_q        <= peak_d;
         outPeak_q     <= outPeak_d;
`endif
      end
   end

   assign out_valid    = (state_q == HOLD);
   assign busy         = (state_q == COUNT);
   assign out_count    = outCount_q;
   assign out_overflow = outOverflow_q;

`ifdef SPIKE_WINDOW_PEAK_EN
   assign out_peak = outPeak_q;
`else
   logic unusedMembrane;
   assign unusedMembrane = ^membrane_in;
   assign out_peak       = '0;
`endif

endmodule

// File: tb/tb_spike_window_counter.sv
// Scoreboard bench for spike_window_counter: each window's expected result is queued when the
// window is driven and compared when the DUT presents it.
module tb_spike_window_counter;

   localparam int CB = 2;
   localparam int WB = 8;
   localparam int MB = 7;
   localparam int MAX_COUNT = (1 << CB) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [WB-1:0] window_len;
   logic          enable;
   logic          spike_in;
   logic [MB-1:0] membrane_in;
   logic          out_valid;
   logic          out_ready;
   logic [CB-1:0] out_count;
   logic          out_overflow;
   logic [MB-1:0] out_peak;
   logic          busy;

   typedef struct {
      int count;
      int ov;
      int peak;
   } result_t;

   result_t expQ[$];
   int      total = 0;
   int      bad = 0;
   int      lastWait;
   int      memPat[16];

   spike_window_counter #(.COUNT_BITS(CB), .WINDOW_BITS(WB), .MEMBRANE_BITS(MB)) dut (
      .clk(clk), .reset(reset), .start(start), .window_len(window_len), .enable(enable),
      .spike_in(spike_in), .membrane_in(membrane_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_count(out_count), .out_overflow(out_overflow), .out_peak(out_peak), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Starts a window at the current negedge, queues its modelled result, then plays the patterns.
   task automatic applyStimulus(input int len, input int n, input logic [15:0] enPat,
                                input logic [15:0] spkPat, input string tag);
      result_t r;
      int seen = 0;
      int spikes = 0;
      int pk = 0;
      for (int i = 0; i < n; i++) begin
         if (enPat[i] && seen < len) begin
            seen++;
            if (spkPat[i]) spikes++;
            if (memPat[i] > pk) pk = memPat[i];
         end
      end
      r.count = (spikes > MAX_COUNT) ? MAX_COUNT : spikes;
      r.ov    = (spikes > MAX_COUNT) ? 1 : 0;
`ifdef SPIKE_WINDOW_PEAK_EN
      r.peak  = pk;
`else
      r.peak  = 0;
`endif
      expQ.push_back(r);
      start      = 1'b1;
      window_len = WB'(len);
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         checkOutput({tag, "_busy"}, int'(busy), (len != 0 && seen < len) ? 1 : 0);
         if (enPat[i] && seen < len) seen++;
         enable      = enPat[i];
         spike_in    = spkPat[i];
         membrane_in = MB'(memPat[i]);
         @(negedge clk);
      end
      enable   = 1'b0;
      spike_in = 1'b0;
   endtask

   // Waits (bounded) for out_valid, compares against the oldest queued result and accepts it.
   task automatic collectResult(input string tag);
      result_t r;
      lastWait = 0;
      while (!out_valid && lastWait < 50) begin
         @(negedge clk);
         lastWait++;
      end
      if (!out_valid) begin
         checkOutput({tag, "_timeout"}, 0, 1);
         return;
      end
      if (expQ.size() == 0) begin
         checkOutput({tag, "_qempty"}, 0, 1);
         return;
      end
      r = expQ.pop_front();
      checkOutput({tag, "_count"}, int'(out_count), r.count);
      checkOutput({tag, "_ovf"}, int'(out_overflow), r.ov);
      checkOutput({tag, "_peak"}, int'(out_peak), r.peak);
      out_ready = 1'b1;
   endtask

   task automatic goIdle();
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; window_len = '0; enable = 1'b0; spike_in = 1'b0;
      membrane_in = '0; out_ready = 1'b0;
      for (int i = 0; i < 16; i++) memPat[i] = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("rst_valid", int'(out_valid), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_count", int'(out_count), 0);
      checkOutput("rst_ovf", int'(out_overflow), 0);
      checkOutput("rst_peak", int'(out_peak), 0);

      // Basic window, spikes 1,0,1,1; result must appear exactly window_len+1 cycles after start.
      applyStimulus(4, 4, 16'h000F, 16'h000D, "t1");
      collectResult("t1");
      checkOutput("t1_latency", lastWait, 0);
      goIdle();
      checkOutput("t1_idle_valid", int'(out_valid), 0);

      // Gaps in enable must not count toward the window.
      applyStimulus(3, 5, 16'h0019, 16'h001F, "t2");
      collectResult("t2");
      checkOutput("t2_latency", lastWait, 0);
      goIdle();

      // Saturation: six spikes into a 2-bit counter.
      applyStimulus(6, 6, 16'h003F, 16'h003F, "t3");
      collectResult("t3");
      goIdle();

      // Peak membrane tracking.
      memPat[0] = 5; memPat[1] = 20; memPat[2] = 12;
      applyStimulus(3, 3, 16'h0007, 16'h0002, "t4");
      collectResult("t4");
      goIdle();
      for (int i = 0; i < 16; i++) memPat[i] = 0;

      // Held result stays stable while the consumer stalls, then chains straight into a new window.
      applyStimulus(2, 2, 16'h0003, 16'h0002, "t5");
      repeat (5) begin
         checkOutput("t5_hold_valid", int'(out_valid), 1);
         checkOutput("t5_hold_count", int'(out_count), expQ[0].count);
         @(negedge clk);
      end
      collectResult("t5");
      applyStimulus(2, 2, 16'h0003, 16'h0003, "t6");
      collectResult("t6");
      checkOutput("t6_latency", lastWait, 0);
      goIdle();

      // Zero-length window: empty result on the very next cycle.
      applyStimulus(0, 0, 16'h0000, 16'h0000, "t7");
      collectResult("t7");
      checkOutput("t7_latency", lastWait, 0);
      goIdle();

      // Randomised windows; at least eight enabled slots guarantee completion.
      for (int k = 0; k < 4; k++) begin
         logic [15:0] en;
         logic [15:0] spk;
         en  = 16'($urandom) | 16'hFF00;
         spk = 16'($urandom);
         for (int i = 0; i < 16; i++) memPat[i] = $urandom_range(0, 127);
         applyStimulus($urandom_range(1, 8), 16, en, spk, "rnd");
         collectResult("rnd");
         goIdle();
      end

      // Reset in the middle of a window discards it and clears the outputs.
      start = 1'b1; window_len = 8'd5;
      @(negedge clk);
      start = 1'b0; enable = 1'b1; spike_in = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("mid_busy_before", int'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; enable = 1'b0; spike_in = 1'b0;
      checkOutput("mid_valid", int'(out_valid), 0);
      checkOutput("mid_busy", int'(busy), 0);
      checkOutput("mid_count", int'(out_count), 0);
      checkOutput("mid_ovf", int'(out_overflow), 0);
      checkOutput("mid_peak", int'(out_peak), 0);

      checkOutput("leftover", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
